// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Coin-return dispenser. Latches a change amount in nickel
//               units, pays it out greedily (quarter, dime, nickel) as timed
//               single-coin pulses, and tracks the contents of each coin tube.
//               Reports completion, the amount paid and any shortfall.
// Ports       : clk, reset (sync, active-high)
//               req/amount          - start request and change amount
//               busy/done/short/paid - transaction status and result
//               coin_*              - registered hopper eject pulses
//               refill_*            - add one coin to the named tube
//               tube_*              - current tube counts
// Build macro : CHANGE_INVENTORY_EN - enables tube counters, refills and
//               shortfall detection; when undefined every tube is treated as
//               non-empty, tube outputs are constant INIT_COUNT, short is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W      = 5,
    parameter int CNT_W      = 6,
    parameter int INIT_COUNT = 10,
    parameter int PULSE_CYC  = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] paid,
    output logic             coin_quarter,
    output logic             coin_dime,
    output logic             coin_nickel,
    input  logic             refill_quarter,
    input  logic             refill_dime,
    input  logic             refill_nickel,
    output logic [CNT_W-1:0] tube_quarter,
    output logic [CNT_W-1:0] tube_dime,
    output logic [CNT_W-1:0] tube_nickel
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SELECT = 3'd1;
    localparam logic [2:0] c_PULSE  = 3'd2;
    localparam logic [2:0] c_GAP    = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    // One down-counter times both the pulse and the gap phases.
    localparam int c_TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    logic [2:0]         r_state;
    logic [AMT_W-1:0]   r_remaining;
    logic [AMT_W-1:0]   r_paid;
    logic [2:0]         r_coin;      // bit 0 quarter, bit 1 dime, bit 2 nickel
    logic [c_TMR_W-1:0] r_tmr;

    logic [2:0]         w_avail;     // tube non-empty, same bit order as r_coin
    logic [2:0]         w_pick;
    logic [AMT_W-1:0]   w_value;

    // Greedy choice: the first denomination that fits and is in stock wins.
    always_comb begin
        w_pick  = 3'b000;
        w_value = '0;
        if (r_remaining >= AMT_W'(5) && w_avail[0]) begin
            w_pick  = 3'b001;
            w_value = AMT_W'(5);
        end else if (r_remaining >= AMT_W'(2) && w_avail[1]) begin
            w_pick  = 3'b010;
            w_value = AMT_W'(2);
        end else if (r_remaining >= AMT_W'(1) && w_avail[2]) begin
            w_pick  = 3'b100;
            w_value = AMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_paid      <= '0;
            r_coin      <= 3'b000;
            r_tmr       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_remaining <= amount;
                        r_paid      <= '0;
                        r_state     <= c_SELECT;
                    end
                end
                c_SELECT: begin
                    if (w_pick != 3'b000) begin
                        r_coin      <= w_pick;
                        r_remaining <= r_remaining - w_value;
                        r_paid      <= r_paid + w_value;
                        r_tmr       <= c_TMR_W'(PULSE_CYC - 1);
                        r_state     <= c_PULSE;
                    end else begin
                        // Either fully paid or nothing in stock fits.
                        r_state <= c_DONE;
                    end
                end
                c_PULSE: begin
                    if (r_tmr == '0) begin
                        r_coin  <= 3'b000;
                        r_tmr   <= c_TMR_W'(GAP_CYC - 1);
                        r_state <= c_GAP;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                c_GAP: begin
                    if (r_tmr == '0) begin
                        r_state <= c_SELECT;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_coin  <= 3'b000;
                end
            endcase
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_DONE);
    assign paid         = r_paid;
    assign coin_quarter = r_coin[0];
    assign coin_dime    = r_coin[1];
    assign coin_nickel  = r_coin[2];

`ifdef CHANGE_INVENTORY_EN
    logic [CNT_W-1:0] r_tube [3];
    logic [2:0]       w_refill;
    logic [2:0]       w_dec;
    logic             r_short;

    assign w_refill = {refill_nickel, refill_dime, refill_quarter};
    // A tube is consumed on the SELECT edge that chooses its coin.
    assign w_dec    = (r_state == c_SELECT) ? w_pick : 3'b000;

    for (genvar gi = 0; gi < 3; gi++) begin : g_avail
        assign w_avail[gi] = (r_tube[gi] != '0);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                r_tube[i] <= CNT_W'(INIT_COUNT);
            end else if (w_refill[i] && !w_dec[i]) begin
                if (r_tube[i] != {CNT_W{1'b1}}) begin
                    r_tube[i] <= r_tube[i] + CNT_W'(1);
                end
            end else if (w_dec[i] && !w_refill[i] && r_tube[i] != '0) begin
                r_tube[i] <= r_tube[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_short <= 1'b0;
        end else if (r_state == c_IDLE && req) begin
            r_short <= 1'b0;
        end else if (r_state == c_SELECT && w_pick == 3'b000 && r_remaining != '0) begin
            r_short <= 1'b1;
        end
    end

    assign short        = r_short;
    assign tube_quarter = r_tube[0];
    assign tube_dime    = r_tube[1];
    assign tube_nickel  = r_tube[2];
`else
    logic w_unused_refill;

    assign w_unused_refill = refill_quarter ^ refill_dime ^ refill_nickel;
    assign w_avail         = 3'b111;
    assign short           = 1'b0;
    assign tube_quarter    = CNT_W'(INIT_COUNT);
    assign tube_dime       = CNT_W'(INIT_COUNT);
    assign tube_nickel     = CNT_W'(INIT_COUNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Directed self-checking bench for change_dispenser. Works in
//               both builds; inventory scenarios are selected with
//               CHANGE_INVENTORY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

`ifdef CHANGE_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [4:0] amount = 5'd0;
    logic       refill_quarter = 1'b0, refill_dime = 1'b0, refill_nickel = 1'b0;
    logic       busy, done, short;
    logic [4:0] paid;
    logic       coin_quarter, coin_dime, coin_nickel;
    logic [5:0] tube_quarter, tube_dime, tube_nickel;

    change_dispenser dut (
        .clk(clk), .reset(reset), .req(req), .amount(amount),
        .busy(busy), .done(done), .short(short), .paid(paid),
        .coin_quarter(coin_quarter), .coin_dime(coin_dime), .coin_nickel(coin_nickel),
        .refill_quarter(refill_quarter), .refill_dime(refill_dime), .refill_nickel(refill_nickel),
        .tube_quarter(tube_quarter), .tube_dime(tube_dime), .tube_nickel(tube_nickel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent run_txn.
    int   t_done_cyc, t_seq, t_ncoins;
    bit   t_timing_ok, t_onehot_ok;
    logic t_busy1;

    // Drives one request (cycle 0 = the IDLE cycle carrying req) and observes
    // outputs on falling edges until done. Coin codes: Q=1, D=2, N=3, packed
    // two bits per coin, first coin most significant.
    task automatic run_txn(input logic [4:0] amt, input bit hold);
        logic [2:0] w, prev;
        int len, cyc, code;
        t_seq = 0; t_ncoins = 0; t_timing_ok = 1'b1; t_onehot_ok = 1'b1;
        t_done_cyc = -1; t_busy1 = 1'b0;
        prev = 3'b000; len = 0; cyc = 0;
        @(negedge clk);
        req = 1'b1; amount = amt;
        while (cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (hold) amount = 5'd7;
            else req = 1'b0;
            if (cyc == 1) t_busy1 = busy;
            w = {coin_quarter, coin_dime, coin_nickel};
            if ($countones(w) > 1) t_onehot_ok = 1'b0;
            if (w != 3'b000) begin
                if (prev == 3'b000) begin
                    t_ncoins++;
                    code = (w == 3'b100) ? 1 : (w == 3'b010) ? 2 : 3;
                    t_seq = t_seq * 4 + code;
                    len = 1;
                    if (cyc != 2 + 4 * (t_ncoins - 1)) t_timing_ok = 1'b0;
                end else if (w != prev) begin
                    t_timing_ok = 1'b0;
                end else begin
                    len++;
                end
            end else if (prev != 3'b000 && len != 2) begin
                t_timing_ok = 1'b0;
            end
            prev = w;
            if (done === 1'b1) begin
                t_done_cyc = cyc;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, short} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b want 000", {busy, done, short}); end
        n_cmp++; if (paid !== 5'd0) begin n_err++; $display("FAIL reset_paid: got %0d want 0", paid); end
        n_cmp++; if ({coin_quarter, coin_dime, coin_nickel} !== 3'b000) begin n_err++; $display("FAIL reset_coins: got %b want 000", {coin_quarter, coin_dime, coin_nickel}); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== {3{6'd10}}) begin n_err++; $display("FAIL reset_tubes: got %0d/%0d/%0d want 10/10/10", tube_quarter, tube_dime, tube_nickel); end
        reset = 1'b0;
    endtask

    task automatic test_greedy_mix;
        run_txn(5'd8, 1'b0);
        n_cmp++; if (t_done_cyc != 14) begin n_err++; $display("FAIL greedy_done_cycle: got %0d want 14", t_done_cyc); end
        n_cmp++; if (t_seq != 27) begin n_err++; $display("FAIL greedy_coin_order: got %0d want 27 (Q,D,N)", t_seq); end
        n_cmp++; if (paid !== 5'd8) begin n_err++; $display("FAIL greedy_paid: got %0d want 8", paid); end
        n_cmp++; if (short !== 1'b0) begin n_err++; $display("FAIL greedy_short: got %b want 0", short); end
        n_cmp++; if (t_timing_ok !== 1'b1) begin n_err++; $display("FAIL greedy_pulse_timing: got %b want 1", t_timing_ok); end
        n_cmp++; if (t_onehot_ok !== 1'b1) begin n_err++; $display("FAIL greedy_onehot: got %b want 1", t_onehot_ok); end
        n_cmp++; if (t_busy1 !== 1'b1) begin n_err++; $display("FAIL greedy_busy_cycle1: got %b want 1", t_busy1); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== (INV ? {3{6'd9}} : {3{6'd10}})) begin n_err++; $display("FAIL greedy_tubes: got %0d/%0d/%0d", tube_quarter, tube_dime, tube_nickel); end
    endtask

    task automatic test_zero;
        run_txn(5'd0, 1'b0);
        n_cmp++; if (t_done_cyc != 2) begin n_err++; $display("FAIL zero_done_cycle: got %0d want 2", t_done_cyc); end
        n_cmp++; if (t_ncoins != 0) begin n_err++; $display("FAIL zero_coins: got %0d want 0", t_ncoins); end
        n_cmp++; if (paid !== 5'd0) begin n_err++; $display("FAIL zero_paid: got %0d want 0", paid); end
    endtask

    task automatic test_back_to_back;
        run_txn(5'd1, 1'b0);
        n_cmp++; if (t_done_cyc != 6 || t_seq != 3) begin n_err++; $display("FAIL b2b_first: got done %0d seq %0d want 6/3", t_done_cyc, t_seq); end
        n_cmp++; if (paid !== 5'd1) begin n_err++; $display("FAIL b2b_first_paid: got %0d want 1", paid); end
        run_txn(5'd2, 1'b0);
        n_cmp++; if (t_busy1 !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b want 1", t_busy1); end
        n_cmp++; if (t_done_cyc != 6 || t_seq != 2) begin n_err++; $display("FAIL b2b_second: got done %0d seq %0d want 6/2", t_done_cyc, t_seq); end
        n_cmp++; if (paid !== 5'd2) begin n_err++; $display("FAIL b2b_second_paid: got %0d want 2", paid); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== (INV ? {6'd9, 6'd8, 6'd8} : {3{6'd10}})) begin n_err++; $display("FAIL b2b_tubes: got %0d/%0d/%0d", tube_quarter, tube_dime, tube_nickel); end
    endtask

    task automatic test_req_ignored;
        run_txn(5'd2, 1'b1);
        n_cmp++; if (t_done_cyc != 6 || t_ncoins != 1) begin n_err++; $display("FAIL ignore_done: got done %0d coins %0d want 6/1", t_done_cyc, t_ncoins); end
        n_cmp++; if (paid !== 5'd2) begin n_err++; $display("FAIL ignore_paid: got %0d want 2", paid); end
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle_after: got busy %b want 0", busy); end
    endtask

`ifdef CHANGE_INVENTORY_EN
    task automatic test_refill_collision;
        int cyc;
        @(negedge clk); req = 1'b1; amount = 5'd5;
        @(negedge clk); req = 1'b0; refill_quarter = 1'b1;
        @(negedge clk); refill_quarter = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        n_cmp++; if (cyc != 6) begin n_err++; $display("FAIL collide_done_cycle: got %0d want 6", cyc); end
        n_cmp++; if (tube_quarter !== 6'd9) begin n_err++; $display("FAIL collide_tube: got %0d want 9", tube_quarter); end
    endtask

    task automatic test_empty_quarter;
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        run_txn(5'd25, 1'b0);
        n_cmp++; if (t_done_cyc != 22 || t_seq != 341) begin n_err++; $display("FAIL drain_q1: got done %0d seq %0d want 22/341", t_done_cyc, t_seq); end
        run_txn(5'd25, 1'b0);
        n_cmp++; if (tube_quarter !== 6'd0) begin n_err++; $display("FAIL drain_q2_tube: got %0d want 0", tube_quarter); end
        run_txn(5'd5, 1'b0);
        n_cmp++; if (t_done_cyc != 14 || t_seq != 43) begin n_err++; $display("FAIL empty_q_seq: got done %0d seq %0d want 14/43 (D,D,N)", t_done_cyc, t_seq); end
        n_cmp++; if (paid !== 5'd5 || short !== 1'b0) begin n_err++; $display("FAIL empty_q_result: got paid %0d short %b want 5/0", paid, short); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== {6'd0, 6'd8, 6'd9}) begin n_err++; $display("FAIL empty_q_tubes: got %0d/%0d/%0d want 0/8/9", tube_quarter, tube_dime, tube_nickel); end
    endtask

    task automatic test_shortfall;
        run_txn(5'd31, 1'b0);
        n_cmp++; if (t_done_cyc != 70 || t_ncoins != 17) begin n_err++; $display("FAIL partial_done: got done %0d coins %0d want 70/17", t_done_cyc, t_ncoins); end
        n_cmp++; if (paid !== 5'd25 || short !== 1'b1) begin n_err++; $display("FAIL partial_result: got paid %0d short %b want 25/1", paid, short); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== 18'd0) begin n_err++; $display("FAIL partial_tubes: got %0d/%0d/%0d want 0/0/0", tube_quarter, tube_dime, tube_nickel); end
        run_txn(5'd3, 1'b0);
        n_cmp++; if (t_done_cyc != 2 || t_ncoins != 0) begin n_err++; $display("FAIL short_done: got done %0d coins %0d want 2/0", t_done_cyc, t_ncoins); end
        n_cmp++; if (paid !== 5'd0 || short !== 1'b1) begin n_err++; $display("FAIL short_result: got paid %0d short %b want 0/1", paid, short); end
        repeat (3) @(negedge clk);
        n_cmp++; if (short !== 1'b1) begin n_err++; $display("FAIL short_hold: got %b want 1", short); end
    endtask

    task automatic test_refill;
        @(negedge clk); refill_dime = 1'b1;
        @(negedge clk); refill_dime = 1'b0;
        n_cmp++; if (tube_dime !== 6'd1) begin n_err++; $display("FAIL refill_inc: got %0d want 1", tube_dime); end
        run_txn(5'd3, 1'b0);
        n_cmp++; if (t_done_cyc != 6 || t_seq != 2) begin n_err++; $display("FAIL refill_txn: got done %0d seq %0d want 6/2", t_done_cyc, t_seq); end
        n_cmp++; if (paid !== 5'd2 || short !== 1'b1) begin n_err++; $display("FAIL refill_result: got paid %0d short %b want 2/1", paid, short); end
    endtask

    task automatic test_saturation;
        refill_nickel = 1'b1;
        repeat (70) @(negedge clk);
        refill_nickel = 1'b0;
        @(negedge clk);
        n_cmp++; if (tube_nickel !== 6'd63) begin n_err++; $display("FAIL saturate: got %0d want 63", tube_nickel); end
        run_txn(5'd0, 1'b0);
        n_cmp++; if (short !== 1'b0) begin n_err++; $display("FAIL short_clear: got %b want 0", short); end
    endtask
`else
    task automatic test_macro_off;
        run_txn(5'd31, 1'b0);
        n_cmp++; if (t_done_cyc != 30 || t_ncoins != 7) begin n_err++; $display("FAIL off_done: got done %0d coins %0d want 30/7", t_done_cyc, t_ncoins); end
        n_cmp++; if (t_seq != 5463) begin n_err++; $display("FAIL off_coin_order: got %0d want 5463 (6Q,N)", t_seq); end
        n_cmp++; if (paid !== 5'd31 || short !== 1'b0) begin n_err++; $display("FAIL off_result: got paid %0d short %b want 31/0", paid, short); end
        n_cmp++; if (t_timing_ok !== 1'b1) begin n_err++; $display("FAIL off_pulse_timing: got %b want 1", t_timing_ok); end
        refill_quarter = 1'b1; refill_dime = 1'b1; refill_nickel = 1'b1;
        repeat (5) @(negedge clk);
        refill_quarter = 1'b0; refill_dime = 1'b0; refill_nickel = 1'b0;
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== {3{6'd10}}) begin n_err++; $display("FAIL off_tubes: got %0d/%0d/%0d want 10/10/10", tube_quarter, tube_dime, tube_nickel); end
    endtask
`endif

    task automatic test_reset_mid_pulse;
        @(negedge clk); req = 1'b1; amount = 5'd5;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        n_cmp++; if (coin_quarter !== 1'b1) begin n_err++; $display("FAIL midrst_pulse_on: got %b want 1", coin_quarter); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, done, short, coin_quarter, coin_dime, coin_nickel} !== 6'b0) begin n_err++; $display("FAIL midrst_outputs: got %b want 000000", {busy, done, short, coin_quarter, coin_dime, coin_nickel}); end
        n_cmp++; if (paid !== 5'd0) begin n_err++; $display("FAIL midrst_paid: got %0d want 0", paid); end
        n_cmp++; if ({tube_quarter, tube_dime, tube_nickel} !== {3{6'd10}}) begin n_err++; $display("FAIL midrst_tubes: got %0d/%0d/%0d want 10/10/10", tube_quarter, tube_dime, tube_nickel); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got busy %b want 0", busy); end
        run_txn(5'd5, 1'b0);
        n_cmp++; if (t_done_cyc != 6 || t_seq != 1 || paid !== 5'd5) begin n_err++; $display("FAIL midrst_recover: got done %0d seq %0d paid %0d want 6/1/5", t_done_cyc, t_seq, paid); end
    endtask

    initial begin
        test_reset();
        test_greedy_mix();
        test_zero();
        test_back_to_back();
        test_req_ignored();
`ifdef CHANGE_INVENTORY_EN
        test_refill_collision();
        test_empty_quarter();
        test_shortfall();
        test_refill();
        test_saturation();
`else
        test_macro_off();
`endif
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Coin-return dispenser for the vending machine. It is the consumer of the vending FSM's `Change` request and the counterpart of the coin-input side: where the vending FSM accepts `quarter`, `nickel` and `dime` pulses, this block emits them toward the coin hopper. It accepts a change amount, pays it out greedily as timed single-coin pulses, tracks the contents of each coin tube, and reports completion, the amount paid and any shortfall.

## Interface
Parameters:
- `AMT_W`, 5: width of amount fields, in nickel units (1 unit = 5 cents).
- `CNT_W`, 6: width of each tube counter; saturates at 2^CNT_W-1.
- `INIT_COUNT`, 10: value loaded into every tube counter on reset.
- `PULSE_CYC`, 2: cycles each coin pulse is held high, minimum 1.
- `GAP_CYC`, 1: low cycles after each pulse, minimum 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: start request. Sampled only in IDLE.
- `amount`, in, AMT_W: change to pay, in nickel units. Captured with `req`.
- `busy`, out, 1: a transaction is in progress.
- `done`, out, 1: one-cycle completion strobe.
- `short`, out, 1: the last transaction could not be paid in full.
- `paid`, out, AMT_W: units dispensed by the last transaction.
- `coin_quarter`, `coin_dime`, `coin_nickel`, out, 1 each: hopper eject pulses.
- `refill_quarter`, `refill_dime`, `refill_nickel`, in, 1 each: add one coin to the named tube.
- `tube_quarter`, `tube_dime`, `tube_nickel`, out, CNT_W each: current tube counts.

## Operation
States: IDLE, SELECT, PULSE, GAP, DONE.
- **IDLE:** `busy`=0. When `req`=1, `amount` is latched into `remaining`, `paid` clears to 0, `short` clears to 0, and the FSM moves to SELECT.
- **SELECT:** coins are chosen greedily, first match wins:
  - `remaining`≥5 and quarter tube >0: quarter.
  - `remaining`≥2 and dime tube >0: dime.
  - `remaining`≥1 and nickel tube >0: nickel.
  - On a choice: go to PULSE, decrement that tube, subtract the coin value (5, 2 or 1) from `remaining`, and add the same value to `paid`.
  - `remaining`=0: go to DONE.
  - `remaining`>0 but no coin fits: set `short`=1 and go to DONE.
- **PULSE:** exactly one coin output is high, for PULSE_CYC cycles. Then GAP.
- **GAP:** all coin outputs low for GAP_CYC cycles. Then SELECT.
- **DONE:** `done`=1 for one cycle. Then IDLE. `short` and `paid` hold until the next accepted `req`.

General rules:
- `busy`=1 in every state except IDLE. `req` is ignored while busy.
- Coin outputs are registered, and at most one is high in any cycle.
- Tube arithmetic:
  - A refill increments its tube, saturating at the maximum.
  - A refill and a decrement of the same tube in the same cycle leave the count unchanged.
  - A tube is never decremented below 0.
  - Refills are accepted in every state.
- All amount arithmetic is unsigned AMT_W; `paid` never exceeds `amount`.

## Timing
- Reset values: `busy`, `done`, `short` and all coin outputs are 0; `paid`=0; state is IDLE; each tube is INIT_COUNT.
- Reset asserted mid-transaction:
  - The next cycle is IDLE with all outputs at their reset values.
  - Any pulse in progress is cut short.
  - Tubes reload to INIT_COUNT.
- `req` high in cycle 0: `busy`=1 and SELECT in cycle 1.
- Each coin takes 1+PULSE_CYC+GAP_CYC cycles.
- For N coins: the final SELECT is in cycle 1+N·(1+PULSE_CYC+GAP_CYC), and `done` follows one cycle later.
- `amount`=0: SELECT in cycle 1, `done` in cycle 2, no coin pulses.
- Back-to-back: `req` may be accepted in the first IDLE cycle after DONE.

## Configuration
- `CHANGE_INVENTORY_EN` defined:
  - Tube counters, refill handling and shortfall detection operate as described above.
- `CHANGE_INVENTORY_EN` undefined:
  - Every tube is treated as non-empty.
  - The tube outputs are constant INIT_COUNT.
  - Refill inputs are ignored, and `short` is constant 0.
  - Ports are identical in both builds.

## Test plan
All scenarios use default parameters and the macro defined unless stated otherwise.
- **Greedy mix:** `amount`=8 -> one quarter, one dime, one nickel in that order. `done` in cycle 14, `paid`=8, `short`=0, tubes 9/9/9.
- **Zero amount:** `amount`=0 -> no coin pulse, `done` in cycle 2, `paid`=0.
- **Empty quarter tube:** quarter tube at 0, `amount`=5 -> dime, dime, nickel; `paid`=5.
- **Shortfall:** all tubes at 0, `amount`=3 -> `done` in cycle 2 with `short`=1 and `paid`=0.
- **Reset mid-pulse:** `amount`=5, `reset` asserted during the first `coin_quarter` pulse -> next cycle all outputs 0, state IDLE, tubes 10.
- **Macro undefined:** `amount`=31 -> six quarters then one nickel, `paid`=31, `short`=0, tubes constant 10.
